// File: rtl/hazard_controller_pkg.sv
// hazard_controller_pkg: shared types and helpers for the pipeline hazard controller.
//   reg_addr_t     : architectural register address (5 bits)
//   bypass_ctrl_e  : per-operand bypass select (NONE/EX/MEM/WB)
//   hazard_track_t : destination info of an in-flight instruction {rd, we, load}
//   occ_state_e    : mul/div occupancy FSM states
package hazard_controller_pkg;
    typedef logic [4:0] reg_addr_t;
    typedef enum logic [1:0] {
        BYPASS_NONE = 2'd0,
        BYPASS_EX   = 2'd1,
        BYPASS_MEM  = 2'd2,
        BYPASS_WB   = 2'd3
    } bypass_ctrl_e;
    typedef struct packed {
        reg_addr_t rd;
        logic      we;
        logic      load;
    } hazard_track_t;
    typedef enum logic {OCC_IDLE, OCC_BUSY} occ_state_e;
    localparam hazard_track_t TRACK_BUBBLE = '0;
    // x0 is hardwired to zero, so a write to it is never a forwarding source
    function automatic logic track_match(logic used, reg_addr_t rs, hazard_track_t t);
        return used && rs != '0 && t.we && t.rd == rs;
    endfunction
    // Youngest producer wins: EX > MEM > WB
    function automatic bypass_ctrl_e bypass_sel(logic ex, logic mem, logic wb);
        return ex ? BYPASS_EX : mem ? BYPASS_MEM : wb ? BYPASS_WB : BYPASS_NONE;
    endfunction
endpackage

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: decode-stage request and hazard-control response bundle.
//   master: drives dec_* / mem_busy / branch_miss, receives bypass selects and stall/flush.
//   slave : the hazard controller side.
//   HAZARD_PERF_CNT_EN adds perf_data_stall/perf_struct_stall/perf_flush counters.
interface hazard_controller_if;
    import hazard_controller_pkg::*;
    logic         dec_valid;
    reg_addr_t    dec_rs1_addr;
    reg_addr_t    dec_rs2_addr;
    logic         dec_rs1_used;
    logic         dec_rs2_used;
    reg_addr_t    dec_rd_addr;
    logic         dec_rd_we;
    logic         dec_is_load;
    logic         dec_is_muldiv;
    logic         mem_busy;
    logic         branch_miss;
    bypass_ctrl_e op1_bypass_ctrl;
    bypass_ctrl_e op2_bypass_ctrl;
    logic         data_hazard;
    logic         structure_stall;
    logic         flush;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]  perf_data_stall;
    logic [31:0]  perf_struct_stall;
    logic [31:0]  perf_flush;
`endif
    modport master (
        output dec_valid, dec_rs1_addr, dec_rs2_addr, dec_rs1_used, dec_rs2_used,
               dec_rd_addr, dec_rd_we, dec_is_load, dec_is_muldiv, mem_busy, branch_miss,
        input  op1_bypass_ctrl, op2_bypass_ctrl, data_hazard, structure_stall, flush
`ifdef HAZARD_PERF_CNT_EN
        , input perf_data_stall, perf_struct_stall, perf_flush
`endif
    );
    modport slave (
        input  dec_valid, dec_rs1_addr, dec_rs2_addr, dec_rs1_used, dec_rs2_used,
               dec_rd_addr, dec_rd_we, dec_is_load, dec_is_muldiv, mem_busy, branch_miss,
        output op1_bypass_ctrl, op2_bypass_ctrl, data_hazard, structure_stall, flush
`ifdef HAZARD_PERF_CNT_EN
        , output perf_data_stall, perf_struct_stall, perf_flush
`endif
    );
endinterface

// File: rtl/hazard_controller_muldiv_occupancy_fsm.sv
// muldiv_occupancy_fsm: keeps the multi-cycle mul/div unit marked busy after issue.
//   clk, rst (sync, active-low), issue (mul/div op enters EX), busy (holds the pipeline).
//   busy stays high for exactly MULDIV_LAT-1 cycles after the issuing edge.
module muldiv_occupancy_fsm
    import hazard_controller_pkg::*;
#(
    parameter int MULDIV_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    output logic busy
);
    // The issue cycle itself is the first EX cycle, so BUSY covers the remaining LAT-1
    localparam logic [3:0] CNT_INIT = 4'(MULDIV_LAT > 1 ? MULDIV_LAT - 2 : 0);
    occ_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == OCC_IDLE) begin
            if (issue && MULDIV_LAT > 1) begin
                state_d = OCC_BUSY;
                cnt_d   = CNT_INIT;
            end
        end else begin
            state_d = cnt_q == '0 ? OCC_IDLE : OCC_BUSY;
            cnt_d   = cnt_q == '0 ? '0 : cnt_q - 4'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= OCC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    assign busy = state_q == OCC_BUSY;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: forwarding selects, load-use bubbles, structural stalls and flush.
//   clk, rst (sync, active-low); hif (slave) carries decode info in, bypass/stall/flush out.
//   MULDIV_LAT: EX occupancy of a mul/div op (1..16).
//   Optional HAZARD_PERF_CNT_EN: saturating cycle counters for data stall, structure stall, flush.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int MULDIV_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_controller_if.slave   hif
);
    hazard_track_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic m1_ex, m1_mem, m1_wb, m2_ex, m2_mem, m2_wb;
    logic data_hazard, structure_stall, flush, kill, advance, issue, muldiv_busy;
    assign m1_ex  = track_match(hif.dec_rs1_used, hif.dec_rs1_addr, ex_q);
    assign m1_mem = track_match(hif.dec_rs1_used, hif.dec_rs1_addr, mem_q);
    assign m1_wb  = track_match(hif.dec_rs1_used, hif.dec_rs1_addr, wb_q);
    assign m2_ex  = track_match(hif.dec_rs2_used, hif.dec_rs2_addr, ex_q);
    assign m2_mem = track_match(hif.dec_rs2_used, hif.dec_rs2_addr, mem_q);
    assign m2_wb  = track_match(hif.dec_rs2_used, hif.dec_rs2_addr, wb_q);
    assign data_hazard     = hif.dec_valid && (m1_ex || m2_ex) && ex_q.load;
    assign structure_stall = hif.mem_busy || muldiv_busy;
    // A held branch_miss waits out the stall; the mul/div ahead of it is never squashed
    assign flush           = hif.branch_miss && !structure_stall;
    assign advance         = !structure_stall;
    assign kill            = !hif.dec_valid || data_hazard || flush;
    assign issue           = advance && !kill && hif.dec_is_muldiv;
    assign hif.op1_bypass_ctrl = bypass_sel(m1_ex, m1_mem, m1_wb);
    assign hif.op2_bypass_ctrl = bypass_sel(m2_ex, m2_mem, m2_wb);
    assign hif.data_hazard     = data_hazard;
    assign hif.structure_stall = structure_stall;
    assign hif.flush           = flush;
    always_comb begin
        ex_d  = !advance ? ex_q : kill ? TRACK_BUBBLE :
                hazard_track_t'{rd: hif.dec_rd_addr, we: hif.dec_rd_we, load: hif.dec_is_load};
        mem_d = advance ? ex_q : mem_q;
        wb_d  = advance ? mem_q : wb_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q  <= TRACK_BUBBLE;
            mem_q <= TRACK_BUBBLE;
            wb_q  <= TRACK_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end
    muldiv_occupancy_fsm #(.MULDIV_LAT(MULDIV_LAT)) u_occ (
        .clk   (clk),
        .rst   (rst),
        .issue (issue),
        .busy  (muldiv_busy)
    );
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_data_q, perf_data_d, perf_struct_q, perf_struct_d, perf_flush_q, perf_flush_d;
    always_comb begin
        perf_data_d   = perf_data_q   + 32'(data_hazard     && perf_data_q   != '1);
        perf_struct_d = perf_struct_q + 32'(structure_stall && perf_struct_q != '1);
        perf_flush_d  = perf_flush_q  + 32'(flush           && perf_flush_q  != '1);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_data_q   <= '0;
            perf_struct_q <= '0;
            perf_flush_q  <= '0;
        end else begin
            perf_data_q   <= perf_data_d;
            perf_struct_q <= perf_struct_d;
            perf_flush_q  <= perf_flush_d;
        end
    end
    assign hif.perf_data_stall   = perf_data_q;
    assign hif.perf_struct_stall = perf_struct_q;
    assign hif.perf_flush        = perf_flush_q;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: table-driven check of forwarding, load-use, mul/div stall, flush and reset.
module tb_hazard_controller;
    localparam logic [1:0] N = 2'd0, E = 2'd1, M = 2'd2, W = 2'd3;
    typedef struct {
        logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
        logic [4:0] rd; logic we; logic ld; logic md; logic mb; logic bm;
        logic [1:0] e1; logic [1:0] e2; logic dh; logic ss; logic fl;
    } vec_t;
    logic clk, rst;
    int tests, fails;
    vec_t tbl[$];
    hazard_controller_if hif();
    hazard_controller #(.MULDIV_LAT(4)) dut (.clk(clk), .rst(rst), .hif(hif));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic vec_t mk(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                                logic [4:0] rd, logic we, logic ld, logic md, logic mb, logic bm,
                                logic [1:0] e1, logic [1:0] e2, logic dh, logic ss, logic fl);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
        t.rd = rd; t.we = we; t.ld = ld; t.md = md; t.mb = mb; t.bm = bm;
        t.e1 = e1; t.e2 = e2; t.dh = dh; t.ss = ss; t.fl = fl;
        return t;
    endfunction
    task automatic drive(input vec_t t);
        hif.dec_valid = t.v; hif.dec_rs1_addr = t.rs1; hif.dec_rs1_used = t.u1;
        hif.dec_rs2_addr = t.rs2; hif.dec_rs2_used = t.u2; hif.dec_rd_addr = t.rd;
        hif.dec_rd_we = t.we; hif.dec_is_load = t.ld; hif.dec_is_muldiv = t.md;
        hif.mem_busy = t.mb; hif.branch_miss = t.bm;
    endtask
    task automatic check(input string name, input vec_t t);
        logic [6:0] act, exp;
        act = {2'(hif.op1_bypass_ctrl), 2'(hif.op2_bypass_ctrl), hif.data_hazard, hif.structure_stall, hif.flush};
        exp = {t.e1, t.e2, t.dh, t.ss, t.fl};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got op1=%0d op2=%0d dh=%b ss=%b fl=%b, want op1=%0d op2=%0d dh=%b ss=%b fl=%b",
                     name, act[6:5], act[4:3], act[2], act[1], act[0], exp[6:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask
`ifdef HAZARD_PERF_CNT_EN
    task automatic check_perf(input string name, input int d, input int s, input int f);
        tests++;
        if (hif.perf_data_stall !== 32'(d) || hif.perf_struct_stall !== 32'(s) || hif.perf_flush !== 32'(f)) begin
            fails++;
            $display("FAIL %s: got data=%0d struct=%0d flush=%0d, want data=%0d struct=%0d flush=%0d",
                     name, hif.perf_data_stall, hif.perf_struct_stall, hif.perf_flush, d, s, f);
        end
    endtask
`endif
    initial begin
        vec_t t;
        tests = 0;
        fails = 0;
        // ADD x5 -> consumer; LW x7 -> load-use bubble then MEM bypass
        tbl.push_back(mk(0,  0,0,  0,0,  0,0,0,0, 0,0, N,N,0,0,0));
        tbl.push_back(mk(1,  0,0,  0,0,  5,1,0,0, 0,0, N,N,0,0,0));
        tbl.push_back(mk(1,  5,1,  0,0,  6,1,0,0, 0,0, E,N,0,0,0));
        tbl.push_back(mk(1,  5,1,  6,1,  7,1,1,0, 0,0, M,E,0,0,0));
        tbl.push_back(mk(1,  5,1,  7,1,  8,1,0,0, 0,0, W,E,1,0,0));
        tbl.push_back(mk(1,  5,1,  7,1,  8,1,0,0, 0,0, N,M,0,0,0));
        // x0 writes fill EX/MEM/WB and never bypass; x3 in EX and MEM picks EX
        tbl.push_back(mk(1,  0,0,  0,0,  0,1,0,0, 0,0, N,N,0,0,0));
        tbl.push_back(mk(1,  8,1,  0,0,  0,1,0,0, 0,0, M,N,0,0,0));
        tbl.push_back(mk(1,  8,1,  0,0,  0,1,0,0, 0,0, W,N,0,0,0));
        tbl.push_back(mk(1,  0,1,  0,1,  3,1,0,0, 0,0, N,N,0,0,0));
        tbl.push_back(mk(1,  0,1,  0,0,  3,1,0,0, 0,0, N,N,0,0,0));
        tbl.push_back(mk(1,  3,1,  3,1,  9,0,0,0, 0,0, E,E,0,0,0));
        tbl.push_back(mk(1,  9,1,  3,1,  0,0,0,0, 0,0, N,M,0,0,0));
        tbl.push_back(mk(0,  3,0,  3,1,  0,0,0,0, 0,0, N,W,0,0,0));
        // MUL x10: 3 stall cycles with EX frozen
        tbl.push_back(mk(1,  0,0,  0,0, 10,1,0,1, 0,0, N,N,0,0,0));
        tbl.push_back(mk(1, 10,1,  0,0, 11,1,0,0, 0,0, E,N,0,1,0));
        tbl.push_back(mk(1, 10,1,  0,0, 11,1,0,0, 0,0, E,N,0,1,0));
        tbl.push_back(mk(1, 10,1,  0,0, 11,1,0,0, 0,0, E,N,0,1,0));
        tbl.push_back(mk(1, 10,1,  0,0, 11,1,0,0, 0,0, E,N,0,0,0));
        tbl.push_back(mk(0, 10,1,  0,0,  0,0,0,0, 0,0, M,N,0,0,0));
        // branch_miss under mem_busy waits, then flushes x12
        tbl.push_back(mk(1, 11,1,  0,0, 12,1,0,0, 1,1, M,N,0,1,0));
        tbl.push_back(mk(1, 11,1,  0,0, 12,1,0,0, 1,1, M,N,0,1,0));
        tbl.push_back(mk(1, 11,1,  0,0, 12,1,0,0, 0,1, M,N,0,0,1));
        tbl.push_back(mk(1, 12,1, 11,1,  0,0,0,0, 0,0, N,W,0,0,0));
        // branch_miss during an active MUL never flushes until it completes
        tbl.push_back(mk(1,  0,0,  0,0, 13,1,0,1, 0,0, N,N,0,0,0));
        tbl.push_back(mk(1, 13,1,  0,0, 14,1,0,0, 0,1, E,N,0,1,0));
        tbl.push_back(mk(1, 13,1,  0,0, 14,1,0,0, 0,1, E,N,0,1,0));
        tbl.push_back(mk(1, 13,1,  0,0, 14,1,0,0, 0,1, E,N,0,1,0));
        tbl.push_back(mk(1, 13,1,  0,0, 14,1,0,0, 0,1, E,N,0,0,1));
        tbl.push_back(mk(0, 13,1,  0,0,  0,0,0,0, 0,0, M,N,0,0,0));
        // load-use requires dec_valid; a load in MEM is no hazard
        tbl.push_back(mk(1, 13,1,  0,0, 15,1,1,0, 0,0, W,N,0,0,0));
        tbl.push_back(mk(0, 15,1,  0,0,  0,0,0,0, 0,0, E,N,0,0,0));
        tbl.push_back(mk(1, 15,1,  0,0,  0,0,0,0, 0,0, M,N,0,0,0));
        drive(mk(0, 0,0, 0,0, 0,0,0,0, 0,0, N,N,0,0,0));
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset", mk(0, 0,0, 0,0, 0,0,0,0, 0,0, N,N,0,0,0));
`ifdef HAZARD_PERF_CNT_EN
        check_perf("perf_reset", 0, 0, 0);
`endif
        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), tbl[i]);
            @(posedge clk);
            #1;
        end
`ifdef HAZARD_PERF_CNT_EN
        check_perf("perf_counts", 1, 8, 2);
`endif
        // rst mid mul/div with a load-tagged op in EX
        t = mk(1, 0,0, 0,0, 16,1,1,1, 0,0, N,N,0,0,0);
        drive(t);
        @(negedge clk);
        check("mul_ld_issue", t);
        @(posedge clk);
        #1;
        t = mk(1, 16,1, 0,0, 17,1,0,0, 0,0, E,N,1,1,0);
        drive(t);
        @(negedge clk);
        check("busy_load_in_ex", t);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        t.e1 = N; t.dh = 1'b0; t.ss = 1'b0;
        @(negedge clk);
        check("after_rst", t);
`ifdef HAZARD_PERF_CNT_EN
        check_perf("perf_after_rst", 0, 0, 0);
`endif
        @(posedge clk);
        #1;
        t = mk(0, 17,1, 0,0, 0,0,0,0, 0,0, E,N,0,0,0);
        drive(t);
        @(negedge clk);
        check("after_rst_next", t);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
